// File: rtl/lvds_pkg.sv
// lvds_pkg: shared constants, pixel/lane types and link state for the dual LVDS packer
package lvds_pkg;
    localparam logic [6:0] LVDS_CLK_PATTERN = 7'b1100011;
    localparam logic [6:0] LVDS_TRAIN_WORD = 7'b1100011;
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;
    typedef logic [3:0][6:0] lanes_t;
    typedef enum logic [1:0] {IDLE, TRAIN, RUN} state_t;
endpackage

// File: rtl/lvds_tx_lane_map.sv
// lvds_tx_lane_map: combinational pixel to four 7-bit LVDS lanes, VESA or JEIDA ordering
module lvds_tx_lane_map
    import lvds_pkg::*;
#(
    parameter bit MAP_JEIDA = 1'b0
) (
    input  pixel_t pix,
    output lanes_t lanes
);
    assign lanes = MAP_JEIDA
        ? lanes_t'({1'b0, pix.b[1:0], pix.g[1:0], pix.r[1:0],
                    pix.de, pix.vs, pix.hs, pix.b[7:4],
                    pix.b[3:2], pix.g[7:3],
                    pix.g[2], pix.r[7:2]})
        : lanes_t'({1'b0, pix.b[7:6], pix.g[7:6], pix.r[7:6],
                    pix.de, pix.vs, pix.hs, pix.b[5:2],
                    pix.b[1:0], pix.g[5:1],
                    pix.g[0], pix.r[5:0]});
endmodule

// File: rtl/lvds_tx_dual_packer.sv
// lvds_tx_dual_packer: pairs pixels into even/odd LVDS channels, gated by PLL lock and link training.
// Define LVDS_TX_TESTPAT_EN to add the test_en port and the 8-bar colour generator.
module lvds_tx_dual_packer
    import lvds_pkg::*;
#(
    parameter bit MAP_JEIDA = 1'b0,
    parameter int unsigned TRAIN_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pll_lock,
`ifdef LVDS_TX_TESTPAT_EN
    input  logic        test_en,
`endif
    input  logic        in_de,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    output logic [27:0] ch0_data,
    output logic [27:0] ch1_data,
    output logic [6:0]  clk_pattern,
    output logic        link_up,
    output logic        odd_line
);
    localparam logic [15:0] LAST = 16'(TRAIN_CYCLES - 1);
    state_t st, st_nx;
    logic lock_s1, lock_s2, phase, de_q, rise, fall;
    logic [15:0] cnt;
    pixel_t cur, even, odd_pix;
    lanes_t map0, map1;

    assign rise = in_de & ~de_q;
    assign fall = ~in_de & de_q;
    assign clk_pattern = LVDS_CLK_PATTERN;

`ifdef LVDS_TX_TESTPAT_EN
    // {bar, pixel-in-bar}: the bar advances every 64 active pixels
    logic [8:0] bar_cnt;
    logic [2:0] bar;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bar_cnt <= '0;
        else if (rise) bar_cnt <= 9'd1;
        else if (in_de) bar_cnt <= bar_cnt + 9'd1;
    end
    assign bar = rise ? 3'd0 : bar_cnt[8:6];
    assign cur = (test_en && st == RUN)
        ? {in_de, in_hs, in_vs, {8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}}
        : {in_de, in_hs, in_vs, in_r, in_g, in_b};
`else
    assign cur = {in_de, in_hs, in_vs, in_r, in_g, in_b};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
        end else begin
            st <= st_nx;
            lock_s1 <= pll_lock;
            lock_s2 <= lock_s1;
        end
    end

    always_comb begin
        st_nx = !lock_s2 ? IDLE :
                st == IDLE ? TRAIN :
                (st == TRAIN && cnt == LAST) ? RUN : st;
    end

    always_comb begin
        link_up = st == RUN;
    end

    // a rising DE on phase 1 flushes the blanking pixel as both halves of its own pair
    assign odd_pix = rise ? even : cur;

    lvds_tx_lane_map #(.MAP_JEIDA(MAP_JEIDA)) u_map0 (.pix(even), .lanes(map0));
    lvds_tx_lane_map #(.MAP_JEIDA(MAP_JEIDA)) u_map1 (.pix(odd_pix), .lanes(map1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            phase <= 1'b0;
            de_q <= 1'b0;
            even <= '0;
            out_valid <= 1'b0;
            ch0_data <= '0;
            ch1_data <= '0;
            odd_line <= 1'b0;
        end else begin
            de_q <= in_de;
            if (st == IDLE || st_nx == IDLE) begin
                cnt <= '0;
                phase <= 1'b0;
                out_valid <= 1'b0;
                ch0_data <= '0;
                ch1_data <= '0;
                odd_line <= 1'b0;
            end else if (st == TRAIN) begin
                cnt <= cnt + 16'd1;
                phase <= st_nx == RUN ? 1'b0 : ~phase;
                out_valid <= phase;
                ch0_data <= {4{LVDS_TRAIN_WORD}};
                ch1_data <= {4{LVDS_TRAIN_WORD}};
                odd_line <= 1'b0;
            end else begin
                phase <= ~phase | rise;
                out_valid <= phase;
                odd_line <= phase & fall;
                if (phase) begin
                    ch0_data <= map0;
                    ch1_data <= map1;
                end
                if (!phase || rise) even <= cur;
            end
        end
    end
endmodule

// File: tb/tb_lvds_tx_dual_packer.sv
// tb_lvds_tx_dual_packer: scoreboard bench driving a VESA and a JEIDA packer from shared stimulus
module tb_lvds_tx_dual_packer;
    import lvds_pkg::*;
    localparam logic [27:0] TRW = {4{7'b1100011}};
    typedef struct packed {
        logic [27:0] v0;
        logic [27:0] v1;
        logic [27:0] j0;
        logic [27:0] j1;
        logic odd;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, pll_lock = 1'b0;
    logic in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0;
    logic [7:0] in_r = '0, in_g = '0, in_b = '0;
    logic v_valid, v_link, v_odd, j_valid, j_link, j_odd;
    logic [27:0] v_ch0, v_ch1, j_ch0, j_ch1;
    logic [6:0] v_clk, j_clk;
    exp_t sb[$];
    exp_t e;
    int total = 0, bad = 0, cyc = 0;
    pixel_t ev;
    logic ph = 1'b0, pde = 1'b0;

    always #5 clk = ~clk;

    lvds_tx_dual_packer #(.MAP_JEIDA(1'b0), .TRAIN_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
`ifdef LVDS_TX_TESTPAT_EN
        .test_en(1'b0),
`endif
        .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs), .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_valid(v_valid), .ch0_data(v_ch0), .ch1_data(v_ch1), .clk_pattern(v_clk),
        .link_up(v_link), .odd_line(v_odd));

    lvds_tx_dual_packer #(.MAP_JEIDA(1'b1), .TRAIN_CYCLES(4)) dutj (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
`ifdef LVDS_TX_TESTPAT_EN
        .test_en(1'b0),
`endif
        .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs), .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_valid(j_valid), .ch0_data(j_ch0), .ch1_data(j_ch1), .clk_pattern(j_clk),
        .link_up(j_link), .odd_line(j_odd));

    function automatic logic [27:0] mdl(pixel_t p, bit j);
        return j ? {1'b0, p.b[1:0], p.g[1:0], p.r[1:0], p.de, p.vs, p.hs, p.b[7:4],
                    p.b[3:2], p.g[7:3], p.g[2], p.r[7:2]}
                 : {1'b0, p.b[7:6], p.g[7:6], p.r[7:6], p.de, p.vs, p.hs, p.b[5:2],
                    p.b[1:0], p.g[5:1], p.g[0], p.r[5:0]};
    endfunction

    function automatic void push(pixel_t a, pixel_t b, logic o);
        sb.push_back(exp_t'({mdl(a, 1'b0), mdl(b, 1'b0), mdl(a, 1'b1), mdl(b, 1'b1), o}));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pix(input logic de, input logic hs, input logic vs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        pixel_t p;
        p = {de, hs, vs, r, g, b};
        {in_de, in_hs, in_vs, in_r, in_g, in_b} = p;
        if (!ph) begin
            ev = p;
            ph = 1'b1;
        end else if (de && !pde) begin
            push(ev, ev, 1'b0);
            ev = p;
        end else begin
            push(ev, p, !de && pde);
            ph = 1'b0;
        end
        pde = de;
        tick();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if ({v_valid, v_odd, v_link} !== {j_valid, j_odd, j_link}) begin
                bad++;
                $display("FAIL ctrl_match cycle %0d: vesa=%b jeida=%b", cyc,
                         {v_valid, v_odd, v_link}, {j_valid, j_odd, j_link});
            end
            total++;
            if (v_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra cycle %0d: out_valid=1 got, no pair expected", cyc);
                end else begin
                    e = sb.pop_front();
                    if ({v_ch0, v_ch1, j_ch0, j_ch1, v_odd} !== e) begin
                        bad++;
                        $display("FAIL sb_pair cycle %0d: got %h %h %h %h %b want %h %h %h %h %b", cyc,
                                 v_ch0, v_ch1, j_ch0, j_ch1, v_odd, e.v0, e.v1, e.j0, e.j1, e.odd);
                    end
                end
            end else if (v_odd !== 1'b0) begin
                bad++;
                $display("FAIL odd_without_valid cycle %0d: odd_line got %b want 0", cyc, v_odd);
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({v_valid, v_ch0, v_ch1, v_link, v_odd} !== '0) begin
            bad++;
            $display("FAIL reset_vesa: got %h want 0", {v_valid, v_ch0, v_ch1, v_link, v_odd});
        end
        total++;
        if ({j_valid, j_ch0, j_ch1, j_link, j_odd} !== '0) begin
            bad++;
            $display("FAIL reset_jeida: got %h want 0", {j_valid, j_ch0, j_ch1, j_link, j_odd});
        end
        total++;
        if ({v_clk, j_clk} !== {2{7'b1100011}}) begin
            bad++;
            $display("FAIL clk_pattern_reset: got %b %b want 1100011", v_clk, j_clk);
        end
        rst_n = 1'b1;
        cyc = 0;
        tick();
        total++;
        if ({v_valid, v_ch0, v_ch1, v_link, v_odd} !== '0) begin
            bad++;
            $display("FAIL idle_outputs: got %h want 0", {v_valid, v_ch0, v_ch1, v_link, v_odd});
        end
    endtask

    task automatic test_lock();
        int nv;
        logic pv, cons;
        while (cyc < 10) tick();
        pll_lock = 1'b1;
        repeat (2) sb.push_back(exp_t'({TRW, TRW, TRW, TRW, 1'b0}));
        nv = 0;
        pv = 1'b0;
        cons = 1'b0;
        for (int k = 11; k <= 17; k++) begin
            tick();
            total++;
            if (v_link !== (k >= 17)) begin
                bad++;
                $display("FAIL link_up cycle %0d: got %b want %b", k, v_link, k >= 17);
            end
            if (k <= 13) begin
                total++;
                if (v_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL early_valid cycle %0d: got %b want 0", k, v_valid);
                end
            end
            if (k >= 13) begin
                nv += int'(v_valid);
                cons |= v_valid & pv;
                pv = v_valid;
            end
        end
        total++;
        if (nv != 2 || cons) begin
            bad++;
            $display("FAIL train_valid_pattern: got %0d pulses consecutive=%b want 2 alternating", nv, cons);
        end
        ph = 1'b0;
        pde = 1'b0;
    endtask

    task automatic test_vesa();
        pix(1'b1, 1'b0, 1'b0, 8'h81, 8'h42, 8'hC3);
        pix(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
        total++;
        if (v_valid !== 1'b1) begin
            bad++;
            $display("FAIL pair_latency: out_valid got %b want 1", v_valid);
        end
        total++;
        if ({v_ch0[27:21], v_ch0[6:0]} !== {7'b0110110, 7'b0000001}) begin
            bad++;
            $display("FAIL vesa_ch0: L3,L0 got %b %b want 0110110 0000001", v_ch0[27:21], v_ch0[6:0]);
        end
        total++;
        if (v_ch1 !== {7'b0111111, {21{1'b1}}}) begin
            bad++;
            $display("FAIL vesa_ch1: got %b want 0111111 then 21 ones", v_ch1);
        end
        total++;
        if ({j_ch0[27:21], j_ch0[6:0]} !== {7'b0111001, 7'b0100000}) begin
            bad++;
            $display("FAIL jeida_ch0: L3,L0 got %b %b want 0111001 0100000", j_ch0[27:21], j_ch0[6:0]);
        end
    endtask

    task automatic test_odd_line();
        logic [11:0] vmask;
        vmask = 12'b010101011010;
        for (int i = 0; i < 12; i++) begin
            logic de;
            de = i >= 3 && i <= 7;
            pix(de, !de, 1'b0, 8'(i * 29 + 3), 8'(i * 53 + 7), 8'(i * 71 + 11));
            total++;
            if (v_valid !== vmask[i]) begin
                bad++;
                $display("FAIL line_valid step %0d: got %b want %b", i, v_valid, vmask[i]);
            end
            total++;
            if (v_odd !== (i == 8)) begin
                bad++;
                $display("FAIL odd_line step %0d: got %b want %b", i, v_odd, i == 8);
            end
            if (i == 8) begin
                total++;
                if (v_ch1[20] !== 1'b0) begin
                    bad++;
                    $display("FAIL odd_ch1_de: got %b want 0", v_ch1[20]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 80; i++) begin
            logic de;
            de = ($urandom_range(0, 4) == 0) ? !pde : pde;
            pix(de, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom), 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_lock_loss();
        for (int i = 0; i < 3; i++) pix(1'b1, 1'b0, 1'b0, 8'(8'h11 * i), 8'h22, 8'h33);
        pll_lock = 1'b0;
        pix(1'b1, 1'b0, 1'b0, 8'h44, 8'h55, 8'h66);
        pix(1'b1, 1'b0, 1'b0, 8'h77, 8'h88, 8'h99);
        in_r = 8'hAB;
        tick();
        total++;
        if ({v_valid, v_ch0, v_ch1, v_link, v_odd, j_valid, j_ch0, j_ch1, j_link, j_odd} !== '0) begin
            bad++;
            $display("FAIL lock_loss_idle: got %b %h %h %b want all zero", v_valid, v_ch0, v_ch1, v_link);
        end
        repeat (2) tick();
        total++;
        if ({v_valid, v_link} !== 2'b00) begin
            bad++;
            $display("FAIL lock_loss_hold: got %b want 00", {v_valid, v_link});
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        {in_de, in_hs, in_vs} = 3'b000;
        pll_lock = 1'b1;
        repeat (2) sb.push_back(exp_t'({TRW, TRW, TRW, TRW, 1'b0}));
        repeat (7) tick();
        ph = 1'b0;
        pde = 1'b0;
        pix(1'b1, 1'b0, 1'b0, 8'hAA, 8'h55, 8'h0F);
        pix(1'b1, 1'b0, 1'b0, 8'hF0, 8'h0F, 8'h5A);
        total++;
        if ({v_valid, v_link} !== 2'b11) begin
            bad++;
            $display("FAIL relock_run: got %b want 11", {v_valid, v_link});
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({v_valid, v_ch0, v_ch1, v_link, v_odd, j_valid, j_ch0, j_ch1, j_link, j_odd} !== '0) begin
            bad++;
            $display("FAIL async_reset: got %b %h %h %b want all zero", v_valid, v_ch0, v_ch1, v_link);
        end
        sb.delete();
        pll_lock = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        total++;
        if ({v_valid, v_link} !== 2'b00) begin
            bad++;
            $display("FAIL post_reset_idle: got %b want 00", {v_valid, v_link});
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_vesa();
        test_odd_line();
        test_back_to_back();
        test_lock_loss();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
